writeback_unit: RTL

Parametrised writeback stage with variable-latency load support. It selects the result (ALU, PC+increment, or aligned and extended load data) and drives the register-file write port one cycle later. While a load waits for its memory response, it holds off upstream with a ready handshake. It also keeps a retired-instruction counter.

---
 rtl/writeback_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU / link / extended-load result and drives the
// register-file write port one cycle later; stalls upstream while a load waits.
module writeback_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_INC     = 4,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_alu_res,
  input  logic [2:0]            in_mem_op,
  input  logic                  in_wb_pc,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [CNT_W-1:0]      retired_count
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int SH_W  = OFF_W + 3;

  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LW  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                  r_state;
  logic [2:0]              r_op;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic                    r_wr;
  logic [OFF_W-1:0]        r_off;
  logic [REG_ADDR_W-1:0]   r_waddr;
  logic [XLEN-1:0]         r_wdata;
  logic                    r_we;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_accept;
  logic                    w_is_load;
  logic [SH_W-1:0]         w_bsh, w_hsh, w_wsh;
  logic [XLEN-1:0]         w_sh_b, w_sh_h, w_sh_w;
  logic [XLEN-1:0]         w_load;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_is_load = (in_mem_op >= OP_LB) && (in_mem_op <= OP_LHU);

  // Halfword drops offset[0]; word lane only moves on 64-bit datapaths.
  assign w_bsh = {r_off, 3'b000};
  assign w_hsh = {r_off[OFF_W-1:1], 4'b0000};
  assign w_wsh = (XLEN == 64) ? {r_off[OFF_W-1], {(SH_W-1){1'b0}}} : '0;

  assign w_sh_b = mem_rsp_data >> w_bsh;
  assign w_sh_h = mem_rsp_data >> w_hsh;
  assign w_sh_w = mem_rsp_data >> w_wsh;

  always_comb begin
    w_load = '0;
    case (r_op)
      OP_LB:   w_load = XLEN'($signed(w_sh_b[7:0]));
      OP_LBU:  w_load = XLEN'(w_sh_b[7:0]);
      OP_LH:   w_load = XLEN'($signed(w_sh_h[15:0]));
      OP_LHU:  w_load = XLEN'(w_sh_h[15:0]);
      OP_LW:   w_load = XLEN'($signed(w_sh_w[31:0]));
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_wr    <= 1'b0;
      r_off   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_load) begin
              r_op    <= in_mem_op;
              r_rd    <= in_rd;
              r_wr    <= in_reg_write;
              r_off   <= in_alu_res[OFF_W-1:0];
              r_state <= WAIT_MEM;
            end else begin
              r_we    <= in_reg_write && (in_rd != '0);
              r_waddr <= in_rd;
              r_wdata <= in_wb_pc ? in_pc + XLEN'(PC_INC) : in_alu_res;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rsp_valid) begin
            r_we    <= r_wr && (r_rd != '0);
            r_waddr <= r_rd;
            r_wdata <= w_load;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_we         = r_we;
  assign rf_waddr      = r_waddr;
  assign rf_wdata      = r_wdata;
  assign retired_count = r_cnt;
endmodule
